// File: rtl/lb_uart_master.sv
// rtl/lb_uart_master.sv - host byte stream to 32-bit local-bus write/read initiator
//
// Frames: opcode 0x00 = write (4 address bytes + 4 data bytes, MSB first),
//         opcode 0x01 = read (4 address bytes); read data goes back as 4 bytes MSB first.
// Other opcodes are dropped in IDLE.
// Optional feature macro: LB_UART_MASTER_TIMEOUT_EN. When it is defined, a read
// that gets no lb_rd_rdy within timeout_cycles returns timeout_data instead.
// Without the macro, a read with no response waits until reset.
//
// Ports:
//   clk_lb     in   single clock
//   reset      in   asynchronous active-high reset
//   rx_byte    in   host byte; rx_rdy marks it valid for one cycle
//   tx_byte    out  response byte; tx_rdy marks it valid for one cycle
//   tx_busy    in   UART busy; no tx_rdy is issued while it is sampled high
//   lb_wr      out  one-cycle write strobe
//   lb_rd      out  one-cycle read strobe
//   lb_addr    out  transaction address; holds between transactions
//   lb_wr_d    out  write data; holds between transactions
//   lb_rd_d    in   read data; valid with lb_rd_rdy
//   lb_rd_rdy  in   read data strobe, only honoured in RD_WAIT
//   busy       out  high whenever the state is not IDLE

module lb_uart_master #(
  parameter int unsigned timeout_cycles = 256,
  parameter logic [31:0] timeout_data   = 32'hDEADBEEF
) (
  input  logic        clk_lb,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_rdy,
  output logic [7:0]  tx_byte,
  output logic        tx_rdy,
  input  logic        tx_busy,
  output logic        lb_wr,
  output logic        lb_rd,
  output logic [31:0] lb_addr,
  output logic [31:0] lb_wr_d,
  input  logic [31:0] lb_rd_d,
  input  logic        lb_rd_rdy,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WR,
    S_RD,
    S_RD_WAIT,
    S_TX
  } state_t;

  state_t      state;
  logic        is_read;
  logic [1:0]  byte_cnt;
  logic [31:0] rsp;

`ifdef LB_UART_MASTER_TIMEOUT_EN
  logic [15:0] tmo_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = ^{timeout_data, timeout_cycles};
`endif

  always_ff @(posedge clk_lb or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      is_read  <= 1'b0;
      byte_cnt <= 2'd0;
      rsp      <= 32'd0;
      tx_byte  <= 8'd0;
      tx_rdy   <= 1'b0;
      lb_wr    <= 1'b0;
      lb_rd    <= 1'b0;
      lb_addr  <= 32'd0;
      lb_wr_d  <= 32'd0;
      busy     <= 1'b0;
`ifdef LB_UART_MASTER_TIMEOUT_EN
      tmo_cnt  <= 16'd0;
`endif
    end else begin
      // Strobes are single-cycle unless a state branch re-asserts them.
      lb_wr  <= 1'b0;
      lb_rd  <= 1'b0;
      tx_rdy <= 1'b0;

      case (state)
        S_IDLE: begin
          if (rx_rdy && (rx_byte[7:1] == 7'd0)) begin
            is_read  <= rx_byte[0];
            byte_cnt <= 2'd0;
            state    <= S_ADDR;
            busy     <= 1'b1;
          end
        end

        S_ADDR: begin
          if (rx_rdy) begin
            lb_addr  <= {lb_addr[23:0], rx_byte};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (is_read) begin
                state <= S_RD;
                lb_rd <= 1'b1;
              end else begin
                state <= S_WDATA;
              end
            end
          end
        end

        S_WDATA: begin
          if (rx_rdy) begin
            lb_wr_d  <= {lb_wr_d[23:0], rx_byte};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state <= S_WR;
              lb_wr <= 1'b1;
            end
          end
        end

        // lb_wr is already high here; just return.
        S_WR: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        S_RD: begin
          state <= S_RD_WAIT;
`ifdef LB_UART_MASTER_TIMEOUT_EN
          tmo_cnt <= 16'd0;
`endif
        end

        S_RD_WAIT: begin
          // Real data takes priority over a timeout expiring in the same cycle.
          if (lb_rd_rdy) begin
            rsp      <= lb_rd_d;
            byte_cnt <= 2'd0;
            state    <= S_TX;
          end
`ifdef LB_UART_MASTER_TIMEOUT_EN
          else if (tmo_cnt == 16'(timeout_cycles - 1)) begin
            rsp      <= timeout_data;
            byte_cnt <= 2'd0;
            state    <= S_TX;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end

        // A pulse is never issued in the cycle right after another one, so
        // the UART always gets a cycle to raise tx_busy.
        S_TX: begin
          if (!tx_rdy && !tx_busy) begin
            tx_rdy   <= 1'b1;
            tx_byte  <= rsp[31:24];
            rsp      <= {rsp[23:0], 8'h00};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lb_uart_master.sv
// tb/tb_lb_uart_master.sv - self-checking bench for lb_uart_master

module tb_lb_uart_master;

  logic        clk_lb;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_rdy;
  logic [7:0]  tx_byte;
  logic        tx_rdy;
  logic        tx_busy;
  logic        lb_wr;
  logic        lb_rd;
  logic [31:0] lb_addr;
  logic [31:0] lb_wr_d;
  logic [31:0] lb_rd_d;
  logic        lb_rd_rdy;
  logic        busy;

  logic        force_busy;
  logic        uart_busy;
  int          uart_cnt;

  assign tx_busy = force_busy | uart_busy;

  lb_uart_master #(
    .timeout_cycles(16),
    .timeout_data  (32'hDEADBEEF)
  ) dut (
    .clk_lb   (clk_lb),
    .reset    (reset),
    .rx_byte  (rx_byte),
    .rx_rdy   (rx_rdy),
    .tx_byte  (tx_byte),
    .tx_rdy   (tx_rdy),
    .tx_busy  (tx_busy),
    .lb_wr    (lb_wr),
    .lb_rd    (lb_rd),
    .lb_addr  (lb_addr),
    .lb_wr_d  (lb_wr_d),
    .lb_rd_d  (lb_rd_d),
    .lb_rd_rdy(lb_rd_rdy),
    .busy     (busy)
  );

  initial clk_lb = 1'b0;
  always #5 clk_lb = ~clk_lb;

  int checks   = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Scoreboard queues, filled when stimulus is driven.
  logic [63:0] exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  logic [7:0]  exp_tx_q[$];

  int   wr_cnt = 0;
  int   rd_cnt = 0;
  int   tx_cnt = 0;
  logic prev_busy  = 1'b0;
  logic prev_txrdy = 1'b0;

  // Monitor plus a simple UART that stays busy for three cycles per byte.
  always @(negedge clk_lb) begin
    if (!reset) begin
      if (lb_wr) begin
        wr_cnt++;
        if (exp_wr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_lb_wr: got addr %h data %h expected no write", lb_addr, lb_wr_d);
        end else begin
          logic [63:0] e;
          e = exp_wr_q.pop_front();
          chk("wr_addr", lb_addr, e[63:32]);
          chk("wr_data", lb_wr_d, e[31:0]);
        end
      end
      if (lb_rd) begin
        rd_cnt++;
        if (exp_rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_lb_rd: got addr %h expected no read", lb_addr);
        end else begin
          chk("rd_addr", lb_addr, exp_rd_q.pop_front());
        end
      end
      if (tx_rdy) begin
        tx_cnt++;
        chk("tx_while_busy", {31'd0, prev_busy}, 32'd0);
        chk("tx_spacing", {31'd0, prev_txrdy}, 32'd0);
        if (exp_tx_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_tx: got %h expected no byte", tx_byte);
        end else begin
          chk("tx_byte", {24'd0, tx_byte}, {24'd0, exp_tx_q.pop_front()});
        end
      end
    end
    if (tx_rdy) uart_cnt = 3;
    else if (uart_cnt > 0) uart_cnt--;
    uart_busy  = (uart_cnt != 0);
    prev_busy  = force_busy | uart_busy;
    prev_txrdy = tx_rdy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    int          dly;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] exp_addr = 32'd0;
  logic [31:0] exp_wd   = 32'd0;

  task automatic send_bytes(input logic [71:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      rx_byte = b[71 - 8*i -: 8];
      rx_rdy  = 1'b1;
      @(posedge clk_lb); #1;
    end
    rx_rdy  = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    if (op == 8'h00)      send_bytes({op, a, d}, 9);
    else if (op == 8'h01) send_bytes({op, a, 32'd0}, 5);
    else                  send_bytes({op, 64'd0}, 1);
  endtask

  task automatic push_read(input logic [31:0] a, input logic [31:0] d);
    exp_rd_q.push_back(a);
    for (int i = 3; i >= 0; i--) exp_tx_q.push_back(d[8*i +: 8]);
  endtask

  task automatic respond(input int dly, input logic [31:0] d);
    repeat (dly) begin @(posedge clk_lb); #1; end
    lb_rd_rdy = 1'b1;
    lb_rd_d   = d;
    @(posedge clk_lb); #1;
    lb_rd_rdy = 1'b0;
    lb_rd_d   = $urandom;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk_lb); #1;
      n++;
    end
    if (busy) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got busy=1 after %0d cycles expected busy=0", name, budget);
    end
    repeat (4) begin @(posedge clk_lb); #1; end
  endtask

  initial begin
    int wr0, rd0, tx0;
    vec_t v;

    vecs[0] = '{8'h00, 32'h00000004, 32'h12345678, 0};
    vecs[1] = '{8'h01, 32'h00000000, 32'hA5C30F01, 3};
    vecs[2] = '{8'h7F, 32'h0,        32'h0,        0};
    vecs[3] = '{8'h00, 32'h89ABCDEF, 32'hFFFFFFFF, 0};
    vecs[4] = '{8'h01, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[5] = '{8'h02, 32'h0,        32'h0,        0};
    vecs[6] = '{8'hFF, 32'h0,        32'h0,        0};
    vecs[7] = '{8'h01, 32'h80000001, 32'h5A5A5A5A, 7};
    vecs[8] = '{8'h00, 32'h00000000, 32'h00000000, 0};

    reset      = 1'b1;
    rx_byte    = 8'h00;
    rx_rdy     = 1'b0;
    lb_rd_d    = 32'h0;
    lb_rd_rdy  = 1'b0;
    force_busy = 1'b0;
    uart_busy  = 1'b0;
    uart_cnt   = 0;
    repeat (3) @(posedge clk_lb);
    #1;
    chk("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
    chk("rst_tx_rdy", {31'd0, tx_rdy}, 32'd0);
    chk("rst_lb_wr", {31'd0, lb_wr}, 32'd0);
    chk("rst_lb_rd", {31'd0, lb_rd}, 32'd0);
    chk("rst_lb_addr", lb_addr, 32'd0);
    chk("rst_lb_wr_d", lb_wr_d, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(posedge clk_lb); #1;

    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      wr0 = wr_cnt; rd0 = rd_cnt; tx0 = tx_cnt;
      if (v.op == 8'h00) begin
        exp_wr_q.push_back({v.addr, v.data});
        exp_addr = v.addr;
        exp_wd   = v.data;
      end else if (v.op == 8'h01) begin
        push_read(v.addr, v.data);
        exp_addr = v.addr;
      end
      send_frame(v.op, v.addr, v.data);
      if (v.op == 8'h00) begin
        chk("wr_latency", {31'd0, lb_wr}, 32'd1);
      end else if (v.op == 8'h01) begin
        chk("rd_latency", {31'd0, lb_rd}, 32'd1);
        respond(v.dly, v.data);
      end else begin
        chk("badop_busy", {31'd0, busy}, 32'd0);
      end
      wait_idle("vec", 200);
      chk("vec_wr_count", wr_cnt - wr0, (v.op == 8'h00) ? 32'd1 : 32'd0);
      chk("vec_rd_count", rd_cnt - rd0, (v.op == 8'h01) ? 32'd1 : 32'd0);
      chk("vec_tx_count", tx_cnt - tx0, (v.op == 8'h01) ? 32'd4 : 32'd0);
      chk("vec_addr_hold", lb_addr, exp_addr);
      chk("vec_wr_d_hold", lb_wr_d, exp_wd);
      chk("vec_busy_end", {31'd0, busy}, 32'd0);
    end

    // lb_rd_rdy while idle must be dropped.
    tx0 = tx_cnt;
    respond(0, 32'h13572468);
    repeat (8) begin @(posedge clk_lb); #1; end
    chk("idle_rdy_busy", {31'd0, busy}, 32'd0);
    chk("idle_rdy_tx", tx_cnt - tx0, 32'd0);

    // Backpressure: UART held busy for 20 cycles across the TX phase.
    push_read(32'h00000040, 32'h11223344);
    exp_addr = 32'h00000040;
    send_frame(8'h01, 32'h00000040, 32'h0);
    chk("bp_rd_latency", {31'd0, lb_rd}, 32'd1);
    repeat (2) begin @(posedge clk_lb); #1; end
    force_busy = 1'b1;
    respond(0, 32'h11223344);
    tx0 = tx_cnt;
    repeat (20) begin @(posedge clk_lb); #1; end
    chk("bp_no_tx", tx_cnt - tx0, 32'd0);
    chk("bp_busy_held", {31'd0, busy}, 32'd1);
    force_busy = 1'b0;
    wait_idle("bp", 200);
    chk("bp_tx_count", tx_cnt - tx0, 32'd4);

    // Reset after three address bytes; partial frame must leave no trace.
    rd0 = rd_cnt;
    send_bytes({8'h01, 8'hAA, 8'hBB, 8'hCC, 40'd0}, 4);
    reset = 1'b1;
    @(posedge clk_lb); #1;
    @(posedge clk_lb); #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_addr", lb_addr, 32'd0);
    reset    = 1'b0;
    exp_addr = 32'd0;
    exp_wd   = 32'd0;
    @(posedge clk_lb); #1;
    push_read(32'hCAFE0010, 32'h0BADF00D);
    send_frame(8'h01, 32'hCAFE0010, 32'h0);
    respond(2, 32'h0BADF00D);
    wait_idle("rst_mid", 200);
    chk("rst_mid_rd_count", rd_cnt - rd0, 32'd1);
    chk("rst_mid_new_addr", lb_addr, 32'hCAFE0010);

`ifdef LB_UART_MASTER_TIMEOUT_EN
    // No responder: timeout word comes back, and a late strobe is dropped.
    tx0 = tx_cnt;
    push_read(32'h00001000, 32'hDEADBEEF);
    send_frame(8'h01, 32'h00001000, 32'h0);
    wait_idle("tmo", 200);
    chk("tmo_tx_count", tx_cnt - tx0, 32'd4);
    respond(0, 32'h24681357);
    repeat (8) begin @(posedge clk_lb); #1; end
    chk("tmo_late_busy", {31'd0, busy}, 32'd0);
    chk("tmo_late_tx", tx_cnt - tx0, 32'd4);
`endif

    chk("sb_empty", exp_wr_q.size() + exp_rd_q.size() + exp_tx_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lb_uart_master.md
# lb_uart_master

Local-bus initiator that turns a host byte stream into single 32-bit local-bus write and read transactions. It drives `lb_wr`/`lb_rd`/`lb_addr`/`lb_wr_d` and collects `lb_rd_d` on `lb_rd_rdy`. It sits between the UART byte engine and the `core` register/SUMP2 responder. Read data is returned to the host as a 4-byte stream.

## Interface
- `timeout_cycles`, default 256: `clk_lb` cycles to wait for `lb_rd_rdy` before a read is abandoned. Legal range 2..65535.
- `timeout_data`, default 32'hDEADBEEF: word returned to the host when a read times out.

Ports:
- `clk_lb`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_byte`  in  8  host command byte.
- `rx_rdy`  in  1  one-cycle strobe; `rx_byte` is valid.
- `tx_byte`  out  8  response byte to the UART.
- `tx_rdy`  out  1  one-cycle strobe; `tx_byte` is valid.
- `tx_busy`  in  1  UART transmitter busy; no `tx_rdy` is issued while high.
- `lb_wr`  out  1  one-cycle write strobe.
- `lb_rd`  out  1  one-cycle read strobe.
- `lb_addr`  out  32  transaction address.
- `lb_wr_d`  out  32  write data.
- `lb_rd_d`  in  32  read data; valid when `lb_rd_rdy` is high.
- `lb_rd_rdy`  in  1  read-data valid strobe from the responder.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Command frame: opcode byte, then 4 address bytes MSB first. Opcode 0x00 (write) is followed by 4 data bytes MSB first. Opcode 0x01 (read) has no further bytes.
- Any other opcode: byte is discarded, state stays IDLE, no bus activity.
- States:
  - IDLE: on `rx_rdy`, 0x00 or 0x01 latches the opcode and goes to ADDR.
  - ADDR: shifts 4 bytes into `lb_addr` (left shift, new byte in [7:0]). After the 4th byte, goes to WDATA for a write or RD for a read.
  - WDATA: shifts 4 bytes into `lb_wr_d` the same way, then goes to WR.
  - WR: `lb_wr`=1 for one cycle, then IDLE.
  - RD: `lb_rd`=1 for one cycle, then RD_WAIT.
  - RD_WAIT: on `lb_rd_rdy`, captures `lb_rd_d` into the response register and goes to TX. Timeout behaviour is set by the Configuration section.
  - TX: sends 4 bytes MSB first, then IDLE.
- `rx_rdy` is ignored in WR, RD, RD_WAIT and TX.
- `lb_rd_rdy` is ignored outside RD_WAIT. A late `lb_rd_rdy` after a timeout is dropped.
- `lb_addr` and `lb_wr_d` hold their last values between transactions. They change only while their bytes are being shifted in.
- Counters: a 2-bit byte counter (wraps 3→0 at the end of each field) and a 16-bit timeout counter, reset on entry to RD_WAIT.
- Reset (any state, including mid-frame or mid-TX) returns to IDLE. Partial frames are discarded and no strobe is issued.

## Timing
- Reset values: `tx_byte`=0, `tx_rdy`=0, `lb_wr`=0, `lb_rd`=0, `lb_addr`=0, `lb_wr_d`=0, `busy`=0.
- All outputs are registered.
- Write: `lb_wr` is high in cycle N+1, where N is the cycle of the 4th data `rx_rdy`. `lb_addr`/`lb_wr_d` are already stable in N+1.
- Read: `lb_rd` is high in cycle N+1, where N is the cycle of the 4th address `rx_rdy`. `lb_rd_rdy` is accepted from N+2 onward.
- First `tx_rdy` comes no earlier than 1 cycle after `lb_rd_rdy` is captured.
- TX handshake: `tx_rdy` pulses one cycle only when `tx_busy` was sampled low. Consecutive `tx_rdy` pulses are at least 2 cycles apart, giving the UART one cycle to raise `tx_busy`.
- `busy` rises in the cycle after the opcode is accepted. It falls in the cycle the state returns to IDLE.
- Back-to-back `rx_rdy` on consecutive cycles must be accepted with no loss.

## Configuration
- `LB_UART_MASTER_TIMEOUT_EN` defined:
  - If the timeout counter reaches `timeout_cycles` in RD_WAIT without `lb_rd_rdy`, the response register loads `timeout_data` and the state goes to TX.
  - If `lb_rd_rdy` and the timeout occur in the same cycle, `lb_rd_rdy` wins.
- Not defined: RD_WAIT waits indefinitely. The timeout counter and `timeout_data` logic are not built; only `reset` recovers a hung read.

## Test plan
- Write: bytes 00 00 00 00 04 12 34 56 78 → single `lb_wr` pulse with `lb_addr`=0x00000004 and `lb_wr_d`=0x12345678; `tx_rdy` never asserts.
- Read: bytes 01 00 00 00 00; responder returns 0xA5C30F01 on `lb_rd_rdy` 3 cycles after `lb_rd` → `tx_byte` sequence A5, C3, 0F, 01; `busy` low afterwards.
- Timeout (macro defined, `timeout_cycles`=16): read with no `lb_rd_rdy` → bytes DE AD BE EF. A later `lb_rd_rdy` is ignored and the state stays IDLE.
- Unknown opcode: bytes 7F, then a valid write frame → no strobe for 7F; the write completes correctly.
- Backpressure: hold `tx_busy`=1 for 20 cycles during TX → no `tx_rdy` while high; all 4 bytes delivered in order after release.
- Reset mid-frame: assert `reset` after 3 address bytes, release, send a full read frame → exactly one `lb_rd` pulse, with `lb_addr` equal to the new address.
